// File: rtl/silife_grid_gen2_if.sv
// rtl/silife_grid_gen2_if.sv - access/control bundle for the silife_grid_gen2 life engine
//
// Ports: master drives en/step/wr_en/row_sel/lane_sel/data_in and observes
// data_out/busy/gen_count/extinct; slave is the grid engine side.
interface silife_grid_gen2_if #(
    parameter int COLS = 16,
    parameter int ROWS = 16,
    parameter int LANE = 8
);
    localparam int RW = $clog2(ROWS);
    localparam int LW = ((COLS / LANE) > 1) ? $clog2(COLS / LANE) : 1;

    logic            en;
    logic            step;
    logic            wr_en;
    logic [RW-1:0]   row_sel;
    logic [LW-1:0]   lane_sel;
    logic [LANE-1:0] data_in;
    logic [LANE-1:0] data_out;
    logic            busy;
    logic [15:0]     gen_count;
    logic            extinct;

    modport master (
        output en, step, wr_en, row_sel, lane_sel, data_in,
        input  data_out, busy, gen_count, extinct
    );

    modport slave (
        input  en, step, wr_en, row_sel, lane_sel, data_in,
        output data_out, busy, gen_count, extinct
    );
endinterface

// File: rtl/silife_grid_gen2.sv
// rtl/silife_grid_gen2.sv - ROWS x COLS Game of Life grid with row-serial update engine
//
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   bus     - silife_grid_gen2_if.slave: en (free-run), step (single generation),
//             wr_en/row_sel/lane_sel/data_in (lane write), data_out (registered
//             lane read), busy, gen_count, extinct
module silife_grid_gen2 #(
    parameter int COLS = 16,
    parameter int ROWS = 16,
    parameter int LANE = 8,
    parameter int WRAP = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    silife_grid_gen2_if.slave   bus
);
    localparam int RW = $clog2(ROWS);
    localparam int NL = COLS / LANE;
    localparam logic [RW-1:0] LAST = RW'(ROWS - 1);

    typedef enum logic {
        IDLE,
        COMPUTE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [RW-1:0]    r;
    logic [COLS-1:0]  grid [ROWS];
    logic [COLS-1:0]  prev_old;
    logic [COLS-1:0]  first_old;
    logic [LANE-1:0]  data_out_q;
    logic [15:0]      gen_q;
    logic             extinct_q;

    logic             busy_c;
    logic             last_row;
    logic             start;
    logic             do_write;
    logic             row_ok;
    logic             lane_ok;
    logic [LANE-1:0]  rd_lane;
    logic             any_live;

    logic [RW-1:0]    r_below;
    logic [COLS-1:0]  above;
    logic [COLS-1:0]  centre;
    logic [COLS-1:0]  below;
    logic [COLS-1:0]  new_row;

    assign row_ok  = (int'(bus.row_sel) < ROWS);
    assign lane_ok = (int'(bus.lane_sel) < NL);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a write cycle in IDLE swallows any step/en
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!bus.wr_en && (bus.en || bus.step)) state_nxt = COMPUTE;
            COMPUTE: if ((r == LAST) && !bus.en)             state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy_c   = (state == COMPUTE);
        last_row = (state == COMPUTE) && (r == LAST);
        start    = (state == IDLE) && !bus.wr_en && (bus.en || bus.step);
        do_write = (state == IDLE) && bus.wr_en && row_ok && lane_ok;
    end

    // Row pointer: held at 0 while idle so every generation begins at row 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
        end else if (busy_c) begin
            r <= (r == LAST) ? '0 : r + 1'b1;
        end else if (start) begin
            r <= '0;
        end
    end

    // Three-row window. Row r-1 has already been overwritten, so its old
    // value comes from prev_old; old row 0 is likewise gone by the last row,
    // hence first_old for the bottom wrap.
    always_comb begin
        r_below = (r == LAST) ? '0 : r + 1'b1;
        centre  = grid[r];
        if (r == '0) begin
            above = (WRAP != 0) ? grid[LAST] : '0;
        end else begin
            above = prev_old;
        end
        if (r == LAST) begin
            below = (WRAP != 0) ? first_old : '0;
        end else begin
            below = grid[r_below];
        end
    end

    // Cell rule per column; edge neighbours are masked off when not wrapping
    for (genvar c = 0; c < COLS; c++) begin : g_cell
        localparam int   CL = (c == 0) ? COLS - 1 : c - 1;
        localparam int   CR = (c == COLS - 1) ? 0 : c + 1;
        localparam logic ML = ((WRAP != 0) || (c != 0)) ? 1'b1 : 1'b0;
        localparam logic MR = ((WRAP != 0) || (c != COLS - 1)) ? 1'b1 : 1'b0;
        logic [3:0] n;

        always_comb begin
            n = {3'b000, above[c]} + {3'b000, below[c]}
              + {3'b000, above[CL] & ML} + {3'b000, centre[CL] & ML} + {3'b000, below[CL] & ML}
              + {3'b000, above[CR] & MR} + {3'b000, centre[CR] & MR} + {3'b000, below[CR] & MR};
        end

        assign new_row[c] = (n == 4'd3) || ((n == 4'd2) && centre[c]);
    end

    // Cell array and the old-row buffers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                grid[i] <= '0;
            end
            prev_old  <= '0;
            first_old <= '0;
        end else if (do_write) begin
            grid[bus.row_sel][bus.lane_sel*LANE +: LANE] <= bus.data_in;
        end else if (busy_c) begin
            grid[r]  <= new_row;
            prev_old <= centre;
            if (r == '0) begin
                first_old <= centre;
            end
        end
    end

    always_comb begin
        rd_lane = '0;
        if (row_ok && lane_ok) begin
            rd_lane = grid[bus.row_sel][bus.lane_sel*LANE +: LANE];
        end
    end

    always_comb begin
        any_live = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            any_live = any_live | (|grid[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
            gen_q      <= '0;
            extinct_q  <= 1'b1;
        end else begin
            data_out_q <= rd_lane;
            extinct_q  <= !any_live;
            if (last_row) begin
                gen_q <= gen_q + 16'd1;
            end
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.busy      = busy_c;
    assign bus.gen_count = gen_q;
    assign bus.extinct   = extinct_q;
endmodule

// File: tb/tb_silife_grid_gen2.sv
// tb/tb_silife_grid_gen2.sv - self-checking bench for silife_grid_gen2 (wrap and no-wrap instances)
module tb_silife_grid_gen2;
    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int LANE = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    silife_grid_gen2_if #(.COLS(COLS), .ROWS(ROWS), .LANE(LANE)) b1 ();
    silife_grid_gen2_if #(.COLS(COLS), .ROWS(ROWS), .LANE(LANE)) b0 ();

    assign b0.en       = b1.en;
    assign b0.step     = b1.step;
    assign b0.wr_en    = b1.wr_en;
    assign b0.row_sel  = b1.row_sel;
    assign b0.lane_sel = b1.lane_sel;
    assign b0.data_in  = b1.data_in;

    silife_grid_gen2 #(.COLS(COLS), .ROWS(ROWS), .LANE(LANE), .WRAP(1)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    silife_grid_gen2 #(.COLS(COLS), .ROWS(ROWS), .LANE(LANE), .WRAP(0)) u_flat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: index 0 = flat grid, 1 = torus. A whole generation is
    // computed at once from the old array, then revealed one row per cycle.
    logic [COLS-1:0] m  [2][ROWS];
    logic [COLS-1:0] nx [2][ROWS];
    bit              m_busy = 1'b0;
    int              m_r = 0;
    int              m_gen = 0;
    logic [7:0]      e_dout [2];
    bit              e_ext [2];

    function automatic bit alive(input int k, input int y, input int x);
        int yy;
        int xx;
        yy = y;
        xx = x;
        if (k == 1) begin
            yy = (y + ROWS) % ROWS;
            xx = (x + COLS) % COLS;
        end else if (y < 0 || y >= ROWS || x < 0 || x >= COLS) begin
            return 1'b0;
        end
        return m[k][yy][xx];
    endfunction

    task automatic compute_next();
        int n;
        for (int k = 0; k < 2; k++)
            for (int y = 0; y < ROWS; y++)
                for (int x = 0; x < COLS; x++) begin
                    n = 0;
                    for (int dy = -1; dy <= 1; dy++)
                        for (int dx = -1; dx <= 1; dx++)
                            if (dy != 0 || dx != 0) n += int'(alive(k, y + dy, x + dx));
                    nx[k][y][x] = (n == 3) || (n == 2 && m[k][y][x]);
                end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int y = 0; y < ROWS; y++) m[k][y] = '0;
                e_dout[k] = '0;
                e_ext[k]  = 1'b1;
            end
            m_busy = 1'b0;
            m_r    = 0;
            m_gen  = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                e_dout[k] = m[k][b1.row_sel][b1.lane_sel*LANE +: LANE];
                e_ext[k]  = 1'b1;
                for (int y = 0; y < ROWS; y++) if (m[k][y] != '0) e_ext[k] = 1'b0;
            end
            if (!m_busy) begin
                if (b1.wr_en) begin
                    for (int k = 0; k < 2; k++) m[k][b1.row_sel][b1.lane_sel*LANE +: LANE] = b1.data_in;
                end else if (b1.en || b1.step) begin
                    m_busy = 1'b1;
                    m_r    = 0;
                    compute_next();
                end
            end else begin
                for (int k = 0; k < 2; k++) m[k][m_r] = nx[k][m_r];
                if (m_r == ROWS - 1) begin
                    m_gen = (m_gen + 1) % 65536;
                    if (b1.en) begin
                        m_r = 0;
                        compute_next();
                    end else begin
                        m_busy = 1'b0;
                    end
                end else begin
                    m_r++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int row, input int lane, input logic [7:0] d);
        b1.row_sel  = 4'(row);
        b1.lane_sel = 1'(lane);
        b1.data_in  = d;
        b1.wr_en    = 1'b1;
        tick();
        b1.wr_en    = 1'b0;
    endtask

    task automatic rd(input int row, input int lane, output logic [7:0] v1, output logic [7:0] v0);
        b1.row_sel  = 4'(row);
        b1.lane_sel = 1'(lane);
        tick();
        v1 = b1.data_out;
        v0 = b0.data_out;
    endtask

    task automatic pulse_step();
        b1.step = 1'b1;
        tick();
        b1.step = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && b1.busy; i++) tick();
        chk("idle_timeout", 32'(b1.busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [7:0] v1, v0;
    int drops;

    initial begin
        b1.en = 1'b0; b1.step = 1'b0; b1.wr_en = 1'b0;
        b1.row_sel = '0; b1.lane_sel = '0; b1.data_in = '0;

        fork
            forever begin
                @(negedge clk);
                chk("cmp_busy",     32'(b1.busy),      32'(m_busy));
                chk("cmp_busy0",    32'(b0.busy),      32'(m_busy));
                chk("cmp_gen",      32'(b1.gen_count), 32'(m_gen));
                chk("cmp_gen0",     32'(b0.gen_count), 32'(m_gen));
                chk("cmp_dout",     32'(b1.data_out),  32'(e_dout[1]));
                chk("cmp_dout0",    32'(b0.data_out),  32'(e_dout[0]));
                chk("cmp_extinct",  32'(b1.extinct),   32'(e_ext[1]));
                chk("cmp_extinct0", 32'(b0.extinct),   32'(e_ext[0]));
            end
            begin
                #500000;
                n_fail++;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (2) tick();
        chk("rst_busy", 32'(b1.busy), 32'd0);
        chk("rst_gen", 32'(b1.gen_count), 32'd0);
        chk("rst_extinct", 32'(b1.extinct), 32'd1);
        chk("rst_dout", 32'(b1.data_out), 32'd0);
        rst_n = 1'b1;
        tick();

        // Blinker
        wr(5, 0, 8'h1C);
        pulse_step();
        wait_idle();
        rd(4, 0, v1, v0); chk("blink_r4", 32'(v1), 32'h08);
        rd(5, 0, v1, v0); chk("blink_r5", 32'(v1), 32'h08);
        rd(6, 0, v1, v0); chk("blink_r6", 32'(v1), 32'h08);
        chk("blink_gen", 32'(b1.gen_count), 32'd1);
        pulse_step();
        wait_idle();
        rd(5, 0, v1, v0); chk("blink2_r5", 32'(v1), 32'h1C);
        rd(4, 0, v1, v0); chk("blink2_r4", 32'(v1), 32'h00);
        rd(6, 0, v1, v0); chk("blink2_r6", 32'(v1), 32'h00);

        // Edge handling: vertical blinker on column 0
        do_reset();
        wr(7, 0, 8'h01); wr(8, 0, 8'h01); wr(9, 0, 8'h01);
        pulse_step();
        wait_idle();
        rd(8, 0, v1, v0);
        chk("edge_wrap_l0", 32'(v1), 32'h03);
        chk("edge_flat_l0", 32'(v0), 32'h03);
        rd(8, 1, v1, v0);
        chk("edge_wrap_l1", 32'(v1), 32'h80);
        chk("edge_flat_l1", 32'(v0), 32'h00);

        // Write during busy is dropped
        do_reset();
        wr(14, 0, 8'h07);
        pulse_step();
        tick();
        wr(15, 0, 8'hFF);
        wait_idle();
        rd(15, 0, v1, v0); chk("busywr_r15", 32'(v1), 32'h02);
        rd(13, 0, v1, v0); chk("busywr_r13", 32'(v1), 32'h02);

        // wr_en together with step in IDLE: write lands, no generation
        b1.row_sel = 4'd0; b1.lane_sel = 1'b1; b1.data_in = 8'h81;
        b1.wr_en = 1'b1; b1.step = 1'b1;
        tick();
        b1.wr_en = 1'b0; b1.step = 1'b0;
        chk("wrstep_busy", 32'(b1.busy), 32'd0);
        tick();
        chk("wrstep_gen", 32'(b1.gen_count), 32'd1);
        rd(0, 1, v1, v0); chk("wrstep_data", 32'(v1), 32'h81);

        // Reset mid-generation at S+7
        pulse_step();
        repeat (6) tick();
        chk("midrst_busy_before", 32'(b1.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(b1.busy), 32'd0);
        chk("midrst_gen", 32'(b1.gen_count), 32'd0);
        chk("midrst_dout", 32'(b1.data_out), 32'd0);
        rd(0, 1, v1, v0); chk("midrst_read", 32'(v1), 32'h00);
        rst_n = 1'b1;
        tick(); tick();
        chk("midrst_extinct", 32'(b1.extinct), 32'd1);

        // Extinction of a single cell
        wr(3, 0, 8'h10);
        tick();
        chk("single_live", 32'(b1.extinct), 32'd0);
        pulse_step();
        repeat (ROWS) tick();
        chk("single_extinct", 32'(b1.extinct), 32'd1);
        chk("single_busy", 32'(b1.busy), 32'd0);

        // Read latency
        wr(1, 0, 8'hA5); wr(2, 0, 8'h5A);
        rd(1, 0, v1, v0); chk("lat_r1", 32'(v1), 32'hA5);
        b1.row_sel = 4'd2;
        #2;
        chk("lat_hold", 32'(b1.data_out), 32'hA5);
        tick();
        chk("lat_r2", 32'(b1.data_out), 32'h5A);

        // Glider on torus for 64 generations
        do_reset();
        wr(0, 0, 8'h02); wr(1, 0, 8'h04); wr(2, 0, 8'h07);
        b1.en = 1'b1;
        @(posedge clk);
        drops = 0;
        for (int i = 0; i < 1023; i++) begin
            @(negedge clk);
            if (!b1.busy) drops++;
            if (i == 1012) b1.en = 1'b0;
        end
        #1;
        wait_idle();
        chk("glider_drops", 32'(drops), 32'd0);
        chk("glider_gen", 32'(b1.gen_count), 32'd64);
        rd(0, 0, v1, v0); chk("glider_r0", 32'(v1), 32'h02);
        rd(1, 0, v1, v0); chk("glider_r1", 32'(v1), 32'h04);
        rd(2, 0, v1, v0); chk("glider_r2", 32'(v1), 32'h07);
        rd(3, 0, v1, v0); chk("glider_r3", 32'(v1), 32'h00);
        rd(0, 1, v1, v0); chk("glider_r0l1", 32'(v1), 32'h00);

        // Randomized traffic, checked every cycle by the compare process
        do_reset();
        for (int i = 0; i < 800; i++) begin
            b1.wr_en    = ($urandom % 4) == 0;
            b1.row_sel  = 4'($urandom_range(0, ROWS - 1));
            b1.lane_sel = 1'($urandom % 2);
            b1.data_in  = 8'($urandom);
            b1.step     = ($urandom % 8) == 0;
            if (($urandom % 60) == 0) b1.en = ~b1.en;
            if (i == 400) rst_n = 1'b0;
            if (i == 402) rst_n = 1'b1;
            tick();
        end
        b1.en = 1'b0; b1.step = 1'b0; b1.wr_en = 1'b0;
        tick();
        wait_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
